decode_queue_stage: RTL and testbench
=====================================

Name: decode_queue_stage

Overview:
- Parametrised successor to the combinational RV32I decoder: a registered ID stage with a DEPTH-entry instruction queue and valid/ready handshakes on both sides.
- Sits between IF and EX. Accepts {pc, inst} from IF, decodes one entry per cycle into a compact registered bundle with sign-extended immediates, and holds that bundle under EX back-pressure.
- Adds optional M-extension decode and optional Zicsr, suppression of rd=x0 writeback, and flush.

Parameters:
- DEPTH, 2: queue entries; legal range 1..8.
- EN_M, 1: 1 = decode MUL/DIV (opcode 0110011, funct7=0000001); 0 = treat these as illegal.
- EN_ZICSR, 1: 1 = decode CSR instructions (opcode 1110011, funct3!=000); 0 = treat these as illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_valid  in  1  IF presents an instruction
- if_ready  out  1  queue can accept; equals count<DEPTH
- pc_if  in  32  instruction PC
- inst_if  in  32  instruction word
- flush  in  1  discard queue and output register (branch/trap redirect)
- ex_valid  out  1  decoded bundle valid
- ex_ready  in  1  EX consumes the bundle this cycle
- pc_ex  out  32  PC of the bundle
- cmd_class_ex  out  12  one-hot class: [0]lui [1]auipc [2]ld [3]alui [4]alu [5]st [6]jal [7]jalr [8]br [9]fence/fence.i [10]csr [11]system
- cmd_mul_ex  out  1  M-extension op; alu_code_ex holds its funct3
- alu_code_ex  out  3  funct3
- alu_sub_ex  out  1  inst[30] for alu / shift-immediate
- sys_code_ex  out  3  0 ecall, 1 ebreak, 2 uret, 3 sret, 4 mret, 5 wfi
- imm_ex  out  32  sign-extended immediate per format: I, S, B, U, J; shamt for shifts; zimm for csr*i
- rs1_ex, rs2_ex, rd_ex  out  5 each  register fields
- wbk_rd_ex  out  1  write rd
- illegal_ex  out  1  undecodable instruction

Behaviour:
- Reset (rst_n=0 at a rising edge): count=0, read/write pointers=0, ex_valid=0. All bundle outputs are 0.
- Push: if_valid & if_ready at an edge writes {pc_if, inst_if} at wptr. wptr wraps DEPTH-1 -> 0.
- Load of output register: it loads the decode of the queue head when the queue is non-empty and (~ex_valid | ex_ready). This pops the head; rptr wraps modulo DEPTH.
- If the queue is empty, ex_valid falls after EX consumes the current bundle.
- Latency: an instruction accepted at edge N appears on ex_valid at edge N+1 when the output register is free. There is no combinational IF->EX path.
- Simultaneous push and pop: count is unchanged. A push into a full queue is allowed when the pop happens in the same cycle? No: if_ready depends only on count, so there is no push into a full queue, even while popping.
- Hold: while ex_valid & ~ex_ready, every bundle output stays stable.
- Flush has priority over push, pop and load in the same cycle. Next cycle: count=0, pointers=0, ex_valid=0, and any if_valid in the flush cycle is dropped.
- Decode:
  - inst[1:0]!=11 -> illegal.
  - Class rules are the RV32I decoder rules, plus: jalr requires funct3=000; fence.i requires funct3=001.
  - Shift-immediate with inst[25]=1 -> illegal.
  - alu (opcode 0110011) requires funct7 of 0000000 or 0100000; funct7=0100000 is legal only for funct3 000 or 101.
  - Legal 0000001 sets cmd_mul_ex when EN_M=1; cmd_class_ex[4] stays 0 for MUL.
- Illegal instruction: it still flows through the stage with illegal_ex=1, cmd_class_ex=0, cmd_mul_ex=0, wbk_rd_ex=0.
- wbk_rd_ex = (lui|auipc|ld|alui|alu|mul|jal|jalr|csr) & (rd!=0).
- Immediate select: csr* with funct3[2]=1 gives {27'b0, inst[19:15]}; shifts give {27'b0, inst[24:20]}.
- NOP (0x00000013): legal alui with wbk_rd_ex=0.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), ex_ready=1 -> one cycle after accept: ex_valid=1, cmd_class_ex=0x008, imm_ex=0xFFFFFFFF, rd_ex=1, wbk_rd_ex=1, illegal_ex=0.
- DEPTH=2, ex_ready=0, if_valid=1 held with 4 distinct insts -> 3 accepted (1 in output register, 2 queued), if_ready=0. Raise ex_ready -> bundles emerge in order with no loss or duplication; pointers wrap correctly.
- mul x3,x1,x2 (0x022081B3): EN_M=1 -> cmd_mul_ex=1, rd_ex=3; EN_M=0 -> illegal_ex=1, wbk_rd_ex=0.
- sw x2,-4(x1) (0xFE20AE23) -> class 0x020, imm_ex=0xFFFFFFFC, wbk_rd_ex=0. beq x0,x0,-8 (0xFE000CE3) -> imm_ex=0xFFFFFFF8. jal x1,+2048 (0x001000EF) -> imm_ex=0x00000800.
- Queue holding 2 entries with ex_valid=1, then flush=1 with if_valid=1 -> next cycle ex_valid=0, if_ready=1. The flush-cycle instruction is never emitted.
- rst_n=0 for one edge mid-stream with a full queue -> ex_valid=0, if_ready=1 (count 0). mret (0x30200073) afterwards -> class 0x800, sys_code_ex=4.

Source files
------------

// File: rtl/decode_queue_stage.sv
// decode_queue_stage
//   Registered RV32I instruction-decode stage between IF and EX. Instructions
//   from IF are written into a DEPTH-entry queue. The head entry is decoded and
//   loaded into a registered bundle. That bundle is held stable while EX
//   applies back-pressure. Optional M-extension and Zicsr decode are
//   controlled by parameters.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   if_valid/if_ready   IF handshake (if_ready = queue not full)
//   pc_if, inst_if      incoming PC and instruction word
//   flush               drop queue contents and the output bundle
//   ex_valid/ex_ready   EX handshake
//   pc_ex .. illegal_ex registered decoded bundle
module decode_queue_stage #(
  parameter int DEPTH    = 2,
  parameter bit EN_M     = 1'b1,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] pc_if,
  input  logic [31:0] inst_if,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] pc_ex,
  output logic [11:0] cmd_class_ex,
  output logic        cmd_mul_ex,
  output logic [2:0]  alu_code_ex,
  output logic        alu_sub_ex,
  output logic [2:0]  sys_code_ex,
  output logic [31:0] imm_ex,
  output logic [4:0]  rs1_ex,
  output logic [4:0]  rs2_ex,
  output logic [4:0]  rd_ex,
  output logic        wbk_rd_ex,
  output logic        illegal_ex
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q_r   [DEPTH];
  logic [31:0]   inst_q_r [DEPTH];
  logic [PW-1:0] wptr_r, rptr_r;
  logic [CW-1:0] count_r, count_next_s;
  logic          push_s, load_s;
  logic [31:0]   head_inst_s;
  logic [11:0]   dec_class_s;
  logic          dec_mul_s, dec_sub_s, dec_illegal_s, dec_wbk_s;
  logic [2:0]    dec_sys_s, f3_s;
  logic [6:0]    f7_s;
  logic [31:0]   dec_imm_s, imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

  // Flush wins over every queue update; if_ready is a registered "not full"
  assign push_s = if_valid & if_ready & ~flush;
  assign load_s = (count_r != '0) & (~ex_valid | ex_ready) & ~flush;

  assign head_inst_s = inst_q_r[rptr_r];
  assign f3_s = head_inst_s[14:12];
  assign f7_s = head_inst_s[31:25];
  assign imm_i_s = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
  assign imm_s_s = {{20{head_inst_s[31]}}, head_inst_s[31:25], head_inst_s[11:7]};
  assign imm_b_s = {{19{head_inst_s[31]}}, head_inst_s[31], head_inst_s[7],
                    head_inst_s[30:25], head_inst_s[11:8], 1'b0};
  assign imm_u_s = {head_inst_s[31:12], 12'h000};
  assign imm_j_s = {{11{head_inst_s[31]}}, head_inst_s[31], head_inst_s[19:12],
                    head_inst_s[20], head_inst_s[30:21], 1'b0};

  // Next occupancy: a simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = '0;
    end else if (push_s && !load_s) begin
      count_next_s = count_r + CW'(1);
    end else if (!push_s && load_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Decode of the queue head; anything not explicitly matched stays illegal
  always_comb begin
    dec_class_s = 12'h000;
    dec_mul_s   = 1'b0;
    dec_sub_s   = 1'b0;
    dec_sys_s   = 3'd0;
    dec_imm_s   = 32'h0000_0000;
    if (head_inst_s[1:0] == 2'b11) begin
      case (head_inst_s[6:2])
        5'b01101: begin dec_class_s[0] = 1'b1; dec_imm_s = imm_u_s; end
        5'b00101: begin dec_class_s[1] = 1'b1; dec_imm_s = imm_u_s; end
        5'b00000: begin
          dec_imm_s = imm_i_s;
          case (f3_s)
            3'b011, 3'b110, 3'b111: dec_class_s = 12'h000;
            default:                dec_class_s[2] = 1'b1;
          endcase
        end
        5'b00100: begin
          case (f3_s)
            3'b001: begin
              dec_class_s[3] = (f7_s == 7'b0000000);
              dec_imm_s = {27'd0, head_inst_s[24:20]};
            end
            3'b101: begin
              dec_class_s[3] = (f7_s == 7'b0000000) | (f7_s == 7'b0100000);
              dec_sub_s = head_inst_s[30];
              dec_imm_s = {27'd0, head_inst_s[24:20]};
            end
            default: begin
              dec_class_s[3] = 1'b1;
              dec_imm_s = imm_i_s;
            end
          endcase
        end
        5'b01100: begin
          if (f7_s == 7'b0000000) begin
            dec_class_s[4] = 1'b1;
          end else if (f7_s == 7'b0100000) begin
            dec_class_s[4] = (f3_s == 3'b000) | (f3_s == 3'b101);
            dec_sub_s = dec_class_s[4];
          end else if (f7_s == 7'b0000001) begin
            dec_mul_s = EN_M;
          end else begin
            dec_class_s = 12'h000;
          end
        end
        5'b01000: begin
          dec_imm_s = imm_s_s;
          dec_class_s[5] = (f3_s == 3'b000) | (f3_s == 3'b001) | (f3_s == 3'b010);
        end
        5'b11011: begin dec_class_s[6] = 1'b1; dec_imm_s = imm_j_s; end
        5'b11001: begin dec_class_s[7] = (f3_s == 3'b000); dec_imm_s = imm_i_s; end
        5'b11000: begin
          dec_imm_s = imm_b_s;
          dec_class_s[8] = (f3_s != 3'b010) & (f3_s != 3'b011);
        end
        5'b00011: begin
          dec_class_s[9] = (f3_s == 3'b000) | (f3_s == 3'b001);
          dec_imm_s = imm_i_s;
        end
        5'b11100: begin
          if (f3_s == 3'b000) begin
            // Privileged ops: rs1, rd and funct3 must all be zero
            if (head_inst_s[19:7] == 13'd0) begin
              dec_class_s[11] = 1'b1;
              case (head_inst_s[31:20])
                12'h000: dec_sys_s = 3'd0;
                12'h001: dec_sys_s = 3'd1;
                12'h002: dec_sys_s = 3'd2;
                12'h102: dec_sys_s = 3'd3;
                12'h302: dec_sys_s = 3'd4;
                12'h105: dec_sys_s = 3'd5;
                default: dec_class_s[11] = 1'b0;
              endcase
            end else begin
              dec_class_s[11] = 1'b0;
            end
          end else if (EN_ZICSR && f3_s != 3'b100) begin
            dec_class_s[10] = 1'b1;
            dec_imm_s = f3_s[2] ? {27'd0, head_inst_s[19:15]} : imm_i_s;
          end else begin
            dec_class_s = 12'h000;
          end
        end
        default: dec_class_s = 12'h000;
      endcase
    end else begin
      dec_class_s = 12'h000;
    end
    dec_illegal_s = ~(|dec_class_s) & ~dec_mul_s;
    dec_wbk_s = (|{dec_class_s[10], dec_class_s[7:6], dec_class_s[4:0]} | dec_mul_s)
                & (head_inst_s[11:7] != 5'd0);
  end

  // Queue storage: written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_q_r[wptr_r]   <= pc_if;
      inst_q_r[wptr_r] <= inst_if;
    end
  end

  // Queue pointers, occupancy and the registered not-full flag
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      count_r  <= '0;
      if_ready <= 1'b1;
    end else begin
      if (push_s) begin
        wptr_r <= (wptr_r == PW'(DEPTH - 1)) ? '0 : wptr_r + PW'(1);
      end
      if (load_s) begin
        rptr_r <= (rptr_r == PW'(DEPTH - 1)) ? '0 : rptr_r + PW'(1);
      end
      count_r  <= count_next_s;
      if_ready <= (count_next_s < CW'(DEPTH));
    end
  end

  // Output bundle: load on pop, drop valid once consumed with nothing behind it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      pc_ex        <= 32'h0000_0000;
      cmd_class_ex <= 12'h000;
      cmd_mul_ex   <= 1'b0;
      alu_code_ex  <= 3'd0;
      alu_sub_ex   <= 1'b0;
      sys_code_ex  <= 3'd0;
      imm_ex       <= 32'h0000_0000;
      rs1_ex       <= 5'd0;
      rs2_ex       <= 5'd0;
      rd_ex        <= 5'd0;
      wbk_rd_ex    <= 1'b0;
      illegal_ex   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load_s) begin
      ex_valid     <= 1'b1;
      pc_ex        <= pc_q_r[rptr_r];
      cmd_class_ex <= dec_class_s;
      cmd_mul_ex   <= dec_mul_s;
      alu_code_ex  <= f3_s;
      alu_sub_ex   <= dec_sub_s;
      sys_code_ex  <= dec_sys_s;
      imm_ex       <= dec_imm_s;
      rs1_ex       <= head_inst_s[19:15];
      rs2_ex       <= head_inst_s[24:20];
      rd_ex        <= head_inst_s[11:7];
      wbk_rd_ex    <= dec_wbk_s;
      illegal_ex   <= dec_illegal_s;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage. A default instance (M and Zicsr on)
// and a reduced instance (both off) share the same stimulus.
module tb_decode_queue_stage;
  logic        clk = 1'b0;
  logic        rst_n, if_valid, flush, ex_ready;
  logic [31:0] pc_if, inst_if;
  logic        if_ready, ex_valid, cmd_mul_ex, alu_sub_ex, wbk_rd_ex, illegal_ex;
  logic [31:0] pc_ex, imm_ex;
  logic [11:0] cmd_class_ex;
  logic [2:0]  alu_code_ex, sys_code_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic        nm_if_ready, nm_ex_valid, nm_mul, nm_sub, nm_wbk, nm_illegal;
  logic [31:0] nm_pc, nm_imm;
  logic [11:0] nm_class;
  logic [2:0]  nm_alu_code, nm_sys;
  logic [4:0]  nm_rs1, nm_rs2, nm_rd;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_queue_stage #(.DEPTH(2), .EN_M(1'b1), .EN_ZICSR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .pc_if(pc_if), .inst_if(inst_if), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .pc_ex(pc_ex), .cmd_class_ex(cmd_class_ex),
    .cmd_mul_ex(cmd_mul_ex), .alu_code_ex(alu_code_ex), .alu_sub_ex(alu_sub_ex),
    .sys_code_ex(sys_code_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .wbk_rd_ex(wbk_rd_ex), .illegal_ex(illegal_ex)
  );

  decode_queue_stage #(.DEPTH(2), .EN_M(1'b0), .EN_ZICSR(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(nm_if_ready),
    .pc_if(pc_if), .inst_if(inst_if), .flush(flush), .ex_valid(nm_ex_valid),
    .ex_ready(ex_ready), .pc_ex(nm_pc), .cmd_class_ex(nm_class),
    .cmd_mul_ex(nm_mul), .alu_code_ex(nm_alu_code), .alu_sub_ex(nm_sub),
    .sys_code_ex(nm_sys), .imm_ex(nm_imm), .rs1_ex(nm_rs1), .rs2_ex(nm_rs2),
    .rd_ex(nm_rd), .wbk_rd_ex(nm_wbk), .illegal_ex(nm_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push one instruction with EX ready, return at the sampling point after load
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    @(negedge clk);
    pc_if = pc; inst_if = inst; if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    check("no_comb_path", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    check("issue_valid", {31'd0, ex_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    pc_if = 32'h0; inst_if = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ready", {31'd0, if_ready}, 32'd1);
    check("rst_class", {20'd0, cmd_class_ex}, 32'h0);
    check("rst_imm", imm_ex, 32'h0);
    rst_n = 1'b1;

    // addi x1,x0,-1
    issue(32'h0000_1000, 32'hFFF0_0093);
    check("addi_class", {20'd0, cmd_class_ex}, 32'h008);
    check("addi_imm", imm_ex, 32'hFFFF_FFFF);
    check("addi_rd", {27'd0, rd_ex}, 32'd1);
    check("addi_wbk", {31'd0, wbk_rd_ex}, 32'd1);
    check("addi_ill", {31'd0, illegal_ex}, 32'd0);
    check("addi_pc", pc_ex, 32'h0000_1000);

    // mul x3,x1,x2 on both instances
    issue(32'h0000_1004, 32'h0220_81B3);
    check("mul_flag", {31'd0, cmd_mul_ex}, 32'd1);
    check("mul_class", {20'd0, cmd_class_ex}, 32'h000);
    check("mul_rd", {27'd0, rd_ex}, 32'd3);
    check("mul_wbk", {31'd0, wbk_rd_ex}, 32'd1);
    check("mul_ill", {31'd0, illegal_ex}, 32'd0);
    check("nm_mul_ill", {31'd0, nm_illegal}, 32'd1);
    check("nm_mul_wbk", {31'd0, nm_wbk}, 32'd0);
    check("nm_mul_flag", {31'd0, nm_mul}, 32'd0);

    // sw x2,-4(x1)
    issue(32'h0000_1008, 32'hFE20_AE23);
    check("sw_class", {20'd0, cmd_class_ex}, 32'h020);
    check("sw_imm", imm_ex, 32'hFFFF_FFFC);
    check("sw_wbk", {31'd0, wbk_rd_ex}, 32'd0);
    // beq x0,x0,-8
    issue(32'h0000_100C, 32'hFE00_0CE3);
    check("beq_class", {20'd0, cmd_class_ex}, 32'h100);
    check("beq_imm", imm_ex, 32'hFFFF_FFF8);
    // jal x1,+2048
    issue(32'h0000_1010, 32'h0010_00EF);
    check("jal_class", {20'd0, cmd_class_ex}, 32'h040);
    check("jal_imm", imm_ex, 32'h0000_0800);
    check("jal_wbk", {31'd0, wbk_rd_ex}, 32'd1);
    // nop
    issue(32'h0000_1014, 32'h0000_0013);
    check("nop_class", {20'd0, cmd_class_ex}, 32'h008);
    check("nop_wbk", {31'd0, wbk_rd_ex}, 32'd0);
    // srai x1,x1,3
    issue(32'h0000_1018, 32'h4030_D093);
    check("srai_class", {20'd0, cmd_class_ex}, 32'h008);
    check("srai_imm", imm_ex, 32'h0000_0003);
    check("srai_sub", {31'd0, alu_sub_ex}, 32'd1);
    check("srai_code", {29'd0, alu_code_ex}, 32'd5);
    // slli with inst[25]=1 is illegal
    issue(32'h0000_101C, 32'h0230_9093);
    check("slli25_ill", {31'd0, illegal_ex}, 32'd1);
    check("slli25_wbk", {31'd0, wbk_rd_ex}, 32'd0);
    check("slli25_class", {20'd0, cmd_class_ex}, 32'h000);
    // sub x3,x1,x2
    issue(32'h0000_1020, 32'h4020_81B3);
    check("sub_class", {20'd0, cmd_class_ex}, 32'h010);
    check("sub_sub", {31'd0, alu_sub_ex}, 32'd1);
    check("sub_rs2", {27'd0, rs2_ex}, 32'd2);
    // lui x5,0x12345
    issue(32'h0000_1024, 32'h1234_52B7);
    check("lui_class", {20'd0, cmd_class_ex}, 32'h001);
    check("lui_imm", imm_ex, 32'h1234_5000);
    // csrrsi x5,mstatus,7
    issue(32'h0000_1028, 32'h3003_E2F3);
    check("csr_class", {20'd0, cmd_class_ex}, 32'h400);
    check("csr_imm", imm_ex, 32'h0000_0007);
    check("csr_wbk", {31'd0, wbk_rd_ex}, 32'd1);
    check("nm_csr_ill", {31'd0, nm_illegal}, 32'd1);
    // low bits != 11, rd=31: illegal, no writeback
    issue(32'h0000_102C, 32'hFFFF_FFFC);
    check("bad_ill", {31'd0, illegal_ex}, 32'd1);
    check("bad_wbk", {31'd0, wbk_rd_ex}, 32'd0);

    // Back-pressure: 4 instructions offered, only 3 accepted while stalled
    @(negedge clk);
    ex_ready = 1'b0;
    pc_if = 32'h100; inst_if = 32'hFFF0_0093; if_valid = 1'b1;
    @(negedge clk);
    check("bp_ready1", {31'd0, if_ready}, 32'd1);
    pc_if = 32'h104; inst_if = 32'h1234_52B7;
    @(negedge clk);
    check("bp_valid2", {31'd0, ex_valid}, 32'd1);
    check("bp_pc2", pc_ex, 32'h100);
    pc_if = 32'h108; inst_if = 32'hFE20_AE23;
    @(negedge clk);
    check("bp_full", {31'd0, if_ready}, 32'd0);
    check("bp_hold_a", pc_ex, 32'h100);
    pc_if = 32'h10C; inst_if = 32'h0010_00EF;
    @(negedge clk);
    check("bp_full2", {31'd0, if_ready}, 32'd0);
    check("bp_hold_b", pc_ex, 32'h100);
    check("bp_hold_imm", imm_ex, 32'hFFFF_FFFF);
    ex_ready = 1'b1;
    @(negedge clk);
    check("bp_out_b", pc_ex, 32'h104);
    check("bp_out_b_class", {20'd0, cmd_class_ex}, 32'h001);
    check("bp_ready_again", {31'd0, if_ready}, 32'd1);
    @(negedge clk);
    if_valid = 1'b0;
    check("bp_out_c", pc_ex, 32'h108);
    check("bp_out_c_class", {20'd0, cmd_class_ex}, 32'h020);
    @(negedge clk);
    check("bp_out_d", pc_ex, 32'h10C);
    check("bp_out_d_imm", imm_ex, 32'h0000_0800);
    check("bp_out_d_valid", {31'd0, ex_valid}, 32'd1);
    @(negedge clk);
    check("bp_drained", {31'd0, ex_valid}, 32'd0);

    // Flush with a full queue and a bundle held
    ex_ready = 1'b0;
    pc_if = 32'h200; inst_if = 32'h0000_0013; if_valid = 1'b1;
    @(negedge clk);
    pc_if = 32'h204;
    @(negedge clk);
    pc_if = 32'h208;
    @(negedge clk);
    check("fl_pre_valid", {31'd0, ex_valid}, 32'd1);
    flush = 1'b1; pc_if = 32'h20C; inst_if = 32'h0010_00EF;
    @(negedge clk);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    check("fl_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_ready", {31'd0, if_ready}, 32'd1);
    repeat (2) @(negedge clk);
    check("fl_nothing", {31'd0, ex_valid}, 32'd0);

    // Flush while the queue is ready: the flush-cycle instruction is dropped
    flush = 1'b1; if_valid = 1'b1; pc_if = 32'h300; inst_if = 32'h0010_00EF;
    @(negedge clk);
    flush = 1'b0; if_valid = 1'b0;
    check("fl2_valid", {31'd0, ex_valid}, 32'd0);
    repeat (2) @(negedge clk);
    check("fl2_dropped", {31'd0, ex_valid}, 32'd0);

    // Reset mid-stream with a full queue
    ex_ready = 1'b0; if_valid = 1'b1; pc_if = 32'h400; inst_if = 32'hFFF0_0093;
    repeat (3) @(negedge clk);
    check("rs_full", {31'd0, if_ready}, 32'd0);
    rst_n = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ex_ready = 1'b1;
    check("rs_valid", {31'd0, ex_valid}, 32'd0);
    check("rs_ready", {31'd0, if_ready}, 32'd1);
    check("rs_pc", pc_ex, 32'h0);
    @(negedge clk);
    check("rs_empty", {31'd0, ex_valid}, 32'd0);

    // mret after reset
    issue(32'h0000_0500, 32'h3020_0073);
    check("mret_class", {20'd0, cmd_class_ex}, 32'h800);
    check("mret_sys", {29'd0, sys_code_ex}, 32'd4);
    check("mret_wbk", {31'd0, wbk_rd_ex}, 32'd0);
    check("mret_pc", pc_ex, 32'h0000_0500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
